// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared limits and pending-response record for the system bus arbiter
package sys_bus_pkg;

   localparam int MaxHosts   = 16;
   localparam int MaxDevices = 16;

   localparam int HostIdxW = $clog2(MaxHosts);
   localparam int DevIdxW  = $clog2(MaxDevices);

   // One outstanding grant; its response comes back exactly one cycle later.
   typedef struct packed {
      logic [HostIdxW-1:0] host;
      logic [DevIdxW-1:0]  dev;
      logic                hit;
      logic                valid;
   } pend_t;

endpackage

// File: rtl/sys_bus_arb_if.sv
// rtl/sys_bus_arb_if.sv - host-side and device-side bus bundle for sys_bus_arb
interface sys_bus_arb_if #(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 4,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);

   logic                      host_req_i    [NrHosts];
   logic                      host_gnt_o    [NrHosts];
   logic [AddressWidth-1:0]   host_addr_i   [NrHosts];
   logic                      host_we_i     [NrHosts];
   logic [DataWidth/8-1:0]    host_be_i     [NrHosts];
   logic [DataWidth-1:0]      host_wdata_i  [NrHosts];
   logic                      host_rvalid_o [NrHosts];
   logic [DataWidth-1:0]      host_rdata_o  [NrHosts];
   logic                      host_err_o    [NrHosts];

   logic                      device_req_o    [NrDevices];
   logic [AddressWidth-1:0]   device_addr_o   [NrDevices];
   logic                      device_we_o     [NrDevices];
   logic [DataWidth/8-1:0]    device_be_o     [NrDevices];
   logic [DataWidth-1:0]      device_wdata_o  [NrDevices];
   logic                      device_rvalid_i [NrDevices];
   logic [DataWidth-1:0]      device_rdata_i  [NrDevices];
   logic                      device_err_i    [NrDevices];

   // The arbiter itself.
   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
      input  device_rvalid_i, device_rdata_i, device_err_i
   );

   // The surrounding hosts and devices.
   modport master (
      output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
      input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
      input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
      output device_rvalid_i, device_rdata_i, device_err_i
   );

endinterface

// File: rtl/sys_bus_rr_arb.sv
// rtl/sys_bus_rr_arb.sv - one-hot host arbiter; SYS_BUS_RR_ARB_EN selects round-robin, else fixed priority
module sys_bus_rr_arb #(
   parameter int NrHosts = 2
) (
`ifdef SYS_BUS_RR_ARB_EN
   input  logic               clk_i,
   input  logic               rst_ni,
`endif
   input  logic [NrHosts-1:0] req_i,
   output logic [NrHosts-1:0] gnt_o
);

   localparam int PW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

   logic          found;
   logic [PW-1:0] idx;

`ifdef SYS_BUS_RR_ARB_EN
   logic [PW-1:0] ptr_q, ptr_d;

   // Search starts at the pointer; the winner's successor becomes the new pointer.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         idx = PW'((int'(ptr_q) + i) % NrHosts);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = (int'(idx) == NrHosts - 1) ? '0 : PW'(int'(idx) + 1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NrHosts; i++) begin
         idx = PW'(i);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/sys_bus_arb.sv
// rtl/sys_bus_arb.sv - multi-host to multi-device bus arbiter with address decode and response routing
// Optional: SYS_BUS_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module sys_bus_arb
   import sys_bus_pkg::*;
#(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 4,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   sys_bus_arb_if.slave            bus,
   input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
   input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

   logic [NrHosts-1:0]      req_vec, gnt_vec;
   logic                    any_gnt, dev_hit;
   logic [HostIdxW-1:0]     sel_host;
   logic [DevIdxW-1:0]      sel_dev;
   logic [AddressWidth-1:0] sel_addr;
   logic                    sel_we;
   logic [DataWidth/8-1:0]  sel_be;
   logic [DataWidth-1:0]    sel_wdata;
   logic [NrDevices-1:0]    dev_sel;
   logic                    rsp_valid, rsp_err;
   logic [DataWidth-1:0]    rsp_data;
   logic                    host_hit;
   pend_t                   pend_q, pend_d;

   // Gating requests with reset keeps grants and device strobes low while reset is held.
   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         req_vec[h] = bus.host_req_i[h] & rst_ni;
      end
   end

   sys_bus_rr_arb #(
      .NrHosts (NrHosts)
   ) u_arb (
`ifdef SYS_BUS_RR_ARB_EN
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
`endif
      .req_i   (req_vec),
      .gnt_o   (gnt_vec)
   );

   always_comb begin : select_and_decode
      any_gnt   = 1'b0;
      sel_host  = '0;
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int h = 0; h < NrHosts; h++) begin
         bus.host_gnt_o[h] = gnt_vec[h];
         if (gnt_vec[h]) begin
            any_gnt   = 1'b1;
            sel_host  = HostIdxW'(h);
            sel_addr  = bus.host_addr_i[h];
            sel_we    = bus.host_we_i[h];
            sel_be    = bus.host_be_i[h];
            sel_wdata = bus.host_wdata_i[h];
         end
      end
      // Scanning downwards lets the lowest matching device overwrite the rest.
      dev_hit = 1'b0;
      sel_dev = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
         if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
            dev_hit = 1'b1;
            sel_dev = DevIdxW'(d);
         end
      end
   end

   always_comb begin : drive_devices
      for (int d = 0; d < NrDevices; d++) begin
         dev_sel[d]            = any_gnt && dev_hit && (sel_dev == DevIdxW'(d));
         bus.device_req_o[d]   = dev_sel[d];
         bus.device_addr_o[d]  = dev_sel[d] ? sel_addr  : '0;
         bus.device_we_o[d]    = dev_sel[d] & sel_we;
         bus.device_be_o[d]    = dev_sel[d] ? sel_be    : '0;
         bus.device_wdata_o[d] = dev_sel[d] ? sel_wdata : '0;
      end
   end

   always_comb begin
      pend_d.valid = any_gnt;
      pend_d.host  = sel_host;
      pend_d.dev   = sel_dev;
      pend_d.hit   = dev_hit;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // An unmapped grant answers itself with an error; mapped ones forward the device reply.
   always_comb begin : route_response
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      host_hit  = 1'b0;
      if (pend_q.valid) begin
         if (pend_q.hit) begin
            for (int d = 0; d < NrDevices; d++) begin
               if (pend_q.dev == DevIdxW'(d)) begin
                  rsp_valid = bus.device_rvalid_i[d];
                  rsp_data  = bus.device_rdata_i[d];
                  rsp_err   = bus.device_err_i[d];
               end
            end
         end else begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
         end
      end
      for (int h = 0; h < NrHosts; h++) begin
         host_hit             = rsp_valid && (pend_q.host == HostIdxW'(h));
         bus.host_rvalid_o[h] = host_hit;
         bus.host_rdata_o[h]  = host_hit ? rsp_data : '0;
         bus.host_err_o[h]    = host_hit & rsp_err;
      end
   end

endmodule

// File: tb/tb_sys_bus_arb.sv
// tb/tb_sys_bus_arb.sv - randomized and directed self-checking bench for sys_bus_arb
module tb_sys_bus_arb;

    localparam int NH = 2;
    localparam int ND = 4;
    localparam int DW = 32;
    localparam int AW = 32;
`ifdef SYS_BUS_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] base [ND];
    logic [AW-1:0] mask [ND];
    logic          spur [ND];

    sys_bus_arb_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

    sys_bus_arb #(
        .NrHosts      (NH),
        .NrDevices    (ND),
        .DataWidth    (DW),
        .AddressWidth (AW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .bus                  (bus),
        .cfg_device_addr_base (base),
        .cfg_device_addr_mask (mask)
    );

    function automatic logic [DW-1:0] dev_data(input logic [AW-1:0] a, input int d);
        return ~a + DW'(d * 16 + 1);
    endfunction

    function automatic logic dev_err(input logic [AW-1:0] a);
        return a[7:0] == 8'hEE;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Devices answer one cycle after their strobe; idle devices may glitch rvalid.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            bus.device_rvalid_i[d] <= bus.device_req_o[d] | spur[d];
            bus.device_rdata_i[d]  <= bus.device_req_o[d] ? dev_data(bus.device_addr_o[d], d) : DW'($urandom);
            bus.device_err_i[d]    <= bus.device_req_o[d] ? dev_err(bus.device_addr_o[d]) : 1'($urandom_range(0, 1));
        end
    end

    int          m_ptr = 0;
    bit          m_pv = 1'b0;
    int          m_ph, m_pd;
    bit          m_phit;
    logic [AW-1:0] m_pa;

    always @(negedge clk) begin
        int g, dv, hh;
        bit ev;
        if (!rst_n) begin
            for (int h = 0; h < NH; h++) begin
                chk("rst_gnt", bus.host_gnt_o[h], 0);
                chk("rst_rvalid", bus.host_rvalid_o[h], 0);
                chk("rst_err", bus.host_err_o[h], 0);
                chk("rst_rdata", bus.host_rdata_o[h], 0);
            end
            for (int d = 0; d < ND; d++) chk("rst_dreq", bus.device_req_o[d], 0);
            m_ptr = 0;
            m_pv  = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < NH; k++) begin
                hh = RR ? (m_ptr + k) % NH : k;
                if (g < 0 && bus.host_req_i[hh]) g = hh;
            end
            dv = -1;
            if (g >= 0) begin
                for (int d = 0; d < ND; d++)
                    if (dv < 0 && (bus.host_addr_i[g] & mask[d]) == base[d]) dv = d;
            end
            for (int h = 0; h < NH; h++) chk("gnt", bus.host_gnt_o[h], 64'(h == g));
            for (int d = 0; d < ND; d++) begin
                chk("dreq", bus.device_req_o[d], 64'(d == dv));
                chk("daddr", bus.device_addr_o[d], (d == dv) ? 64'(bus.host_addr_i[g]) : 0);
                chk("dwe", bus.device_we_o[d], (d == dv) ? 64'(bus.host_we_i[g]) : 0);
                chk("dbe", bus.device_be_o[d], (d == dv) ? 64'(bus.host_be_i[g]) : 0);
                chk("dwdata", bus.device_wdata_o[d], (d == dv) ? 64'(bus.host_wdata_i[g]) : 0);
            end
            for (int h = 0; h < NH; h++) begin
                ev = m_pv && (m_ph == h);
                chk("rvalid", bus.host_rvalid_o[h], 64'(ev));
                chk("rdata", bus.host_rdata_o[h], (ev && m_phit) ? 64'(dev_data(m_pa, m_pd)) : 0);
                chk("rerr", bus.host_err_o[h], ev ? (m_phit ? 64'(dev_err(m_pa)) : 1) : 0);
            end
            m_pv = (g >= 0);
            if (g >= 0) begin
                m_ph   = g;
                m_pd   = dv;
                m_phit = (dv >= 0);
                m_pa   = bus.host_addr_i[g];
                if (RR) m_ptr = (g + 1) % NH;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic host_set(input int h, input logic r, input logic [AW-1:0] a, input logic w);
        bus.host_req_i[h]   = r;
        bus.host_addr_i[h]  = a;
        bus.host_we_i[h]    = w;
        bus.host_be_i[h]    = 4'hF;
        bus.host_wdata_i[h] = $urandom;
    endtask

    task automatic idle_all();
        for (int h = 0; h < NH; h++) host_set(h, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [ND-1:0] dreq_vec();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = bus.device_req_o[d];
        return v;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 9))
            0: return 32'h0010_0004;
            1: return 32'h0010_0ABC;
            2: return 32'h0002_00EE;
            3: return 32'h0002_0000;
            4: return 32'h0003_0010;
            5: return 32'h0000_0000;
            6: return 32'h0000_5000;
            7: return 32'h4000_0004;
            8: return 32'h7FFF_FFF0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        base[0] = 32'h0010_0000; mask[0] = 32'hFFF0_0000;
        base[1] = 32'h0002_0000; mask[1] = 32'hFFFF_0000;
        base[2] = 32'h0003_0000; mask[2] = 32'hFFFF_0000;
        base[3] = 32'h4000_0000; mask[3] = 32'hF000_0000;
        for (int d = 0; d < ND; d++) spur[d] = 1'b0;
        idle_all();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;

        host_set(0, 1'b1, 32'h0010_0004, 1'b1);
        smp();
        chk("t029_gnt", bus.host_gnt_o[0], 1);
        chk("t029_dreq", dreq_vec(), 4'b0001);
        chk("t029_daddr", bus.device_addr_o[0], 32'h0010_0004);
        cyc(); idle_all(); smp();
        chk("t029_rvalid", bus.host_rvalid_o[0], 1);
        chk("t029_err", bus.host_err_o[0], 0);
        chk("t029_rdata", bus.host_rdata_o[0], 32'hFFEF_FFFC);

        cyc(); host_set(0, 1'b1, 32'h0, 1'b0); smp();
        chk("t030_gnt", bus.host_gnt_o[0], 1);
        chk("t030_dreq", dreq_vec(), 4'b0000);
        cyc(); idle_all(); smp();
        chk("t030_rvalid", bus.host_rvalid_o[0], 1);
        chk("t030_err", bus.host_err_o[0], 1);
        chk("t030_rdata", bus.host_rdata_o[0], 0);

        cyc(); rst_n = 1'b0; cyc(); cyc();
        rst_n = 1'b1;
        host_set(0, 1'b1, 32'h0002_0000, 1'b0);
        host_set(1, 1'b1, 32'h0002_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t031_gnt", {bus.host_gnt_o[1], bus.host_gnt_o[0]},
                (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
            cyc();
        end
        idle_all();

        host_set(0, 1'b1, 32'h0002_0000, 1'b0);
        smp(); cyc();
        host_set(0, 1'b1, 32'h0003_0000, 1'b0);
        smp();
        chk("t032_rvalid1", bus.host_rvalid_o[0], 1);
        chk("t032_rdata1", bus.host_rdata_o[0], 32'hFFFE_0010);
        chk("t032_dreq2", dreq_vec(), 4'b0100);
        cyc(); idle_all(); smp();
        chk("t032_rvalid2", bus.host_rvalid_o[0], 1);
        chk("t032_rdata2", bus.host_rdata_o[0], 32'hFFFD_0020);

        cyc();
        mask[1] = 32'hFFFE_0000;
        host_set(0, 1'b1, 32'h0003_0000, 1'b0);
        smp();
        chk("t034_dreq", dreq_vec(), 4'b0010);
        cyc(); idle_all();
        mask[1] = 32'hFFFF_0000;

        host_set(0, 1'b1, 32'h0002_0000, 1'b0);
        smp();
        chk("t033_gnt", bus.host_gnt_o[0], 1);
        cyc(); idle_all(); rst_n = 1'b0; smp();
        chk("t033_rvalid_rst", bus.host_rvalid_o[0], 0);
        cyc(); cyc(); rst_n = 1'b1; smp();
        chk("t033_rvalid_rel", bus.host_rvalid_o[0], 0);
        cyc();
        host_set(0, 1'b1, 32'h0002_0000, 1'b0);
        host_set(1, 1'b1, 32'h0002_0000, 1'b0);
        smp();
        chk("t033_ptr0", {bus.host_gnt_o[1], bus.host_gnt_o[0]}, 2'b01);
        cyc(); idle_all();

        for (int n = 0; n < 1500; n++) begin
            for (int h = 0; h < NH; h++) begin
                host_set(h, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)));
                bus.host_be_i[h] = 4'($urandom);
            end
            for (int d = 0; d < ND; d++) spur[d] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0)
                mask[1] = (mask[1] == 32'hFFFF_0000) ? 32'hFFFE_0000 : 32'hFFFF_0000;
            rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1;
        idle_all();
        for (int d = 0; d < ND; d++) spur[d] = 1'b0;
        cyc(); cyc();
        smp();
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
